// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU slice: control encodings and
// the arbiter FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU shared by the requesters behind alu_arbiter.
// Unknown control codes return zero with the zero flag set.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant and wraps;
// the pointer moves only when the caller strobes advance on an accept.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] last_grant;
  logic             found;
  int               idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
  end

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (advance && found) begin
      // NOTE: sequential state is always updated with non-blocking assignments.
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ valid/ready requesters,
// one operation in flight: IDLE (accept) -> EXEC (capture) -> RESP (hold).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_zero,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [CTRL_W-1:0]         alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  arb_state_t         state;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic               accept;

  logic [DATA_W-1:0]  a_arr    [NUM_REQ];
  logic [DATA_W-1:0]  b_arr    [NUM_REQ];
  logic [CTRL_W-1:0]  ctrl_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]    = req_a[i*DATA_W +: DATA_W];
    assign b_arr[i]    = req_b[i*DATA_W +: DATA_W];
    assign ctrl_arr[i] = req_ctrl[i*CTRL_W +: CTRL_W];
  end

  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      grant_id   <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= a_arr[win_idx];
            alu_b    <= b_arr[win_idx];
            alu_ctrl <= ctrl_arr[win_idx];
            grant_id <= win_idx;
            state    <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= alu_result;
          resp_zero  <= alu_zero;
          resp_valid <= NUM_REQ'(1) << grant_id;
          state      <= RESP;
        end
        RESP: begin
          // Only the granted requester's resp_ready can complete the response.
          if (resp_ready[grant_id]) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with the real ALU attached.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [5:0]   req_ctrl;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [63:0]  resp_data;
  logic         resp_zero;
  logic [63:0]  alu_a;
  logic [63:0]  alu_b;
  logic [2:0]   alu_ctrl;
  logic [63:0]  alu_result;
  logic         alu_zero;
  logic         busy;
  logic [0:0]   grant_id;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_arbiter #(
    .NUM_REQ (2),
    .DATA_W  (64),
    .CTRL_W  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  alu #(.DATA_W(64)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] c);
    req_a[idx*64 +: 64]  = a;
    req_b[idx*64 +: 64]  = b;
    req_ctrl[idx*3 +: 3] = c;
  endtask

  // Issues one operation on requester idx and returns what the DUT showed.
  task automatic do_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] c, output logic [0:0] gid,
                       output logic [1:0] rv, output logic [63:0] data,
                       output logic zero, output bit ok);
    set_req(idx, a, b, c);
    req_valid[idx] = 1'b1;
    resp_ready     = 2'b11;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready[idx]) ok = 1'b1;
      else tick();
    end
    gid = 1'b0; rv = '0; data = '0; zero = 1'b0;
    if (!ok) begin
      req_valid[idx] = 1'b0;
      return;
    end
    tick();
    req_valid[idx] = 1'b0;
    gid = grant_id;
    ok  = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (resp_valid != 2'b00) ok = 1'b1;
      else tick();
    end
    rv   = resp_valid;
    data = resp_data;
    zero = resp_zero;
    tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 2'b11;
    req_a      = '0;
    req_b      = '0;
    req_ctrl   = '0;
    #12;
    n_cmp++;
    if ({req_ready, resp_valid, busy, grant_id} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b rv=%b busy=%b gid=%0d want all 0",
               req_ready, resp_valid, busy, grant_id);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_ctrl, resp_data, resp_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got a=%h b=%h ctrl=%b data=%h z=%b want all 0",
               alu_a, alu_b, alu_ctrl, resp_data, resp_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    set_req(0, 64'd5, 64'd7, ALU_ADD);
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL add_ready: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if ({busy, resp_valid, alu_a, alu_b, alu_ctrl, grant_id} !==
        {1'b1, 2'b00, 64'd5, 64'd7, ALU_ADD, 1'b0}) begin
      n_fail++;
      $display("FAIL add_exec: got busy=%b rv=%b a=%h b=%h ctrl=%b gid=%0d want 1 00 5 7 010 0",
               busy, resp_valid, alu_a, alu_b, alu_ctrl, grant_id);
    end
    tick();
    n_cmp++;
    if ({resp_valid, resp_data, resp_zero} !== {2'b01, 64'd12, 1'b0}) begin
      n_fail++;
      $display("FAIL add_resp: got rv=%b data=%h z=%b want 01 c 0", resp_valid, resp_data, resp_zero);
    end
    tick();
    n_cmp++;
    if ({resp_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL add_idle: got rv=%b busy=%b want 00 0", resp_valid, busy);
    end
  endtask

  task automatic test_sub_backpressure();
    resp_ready = 2'b01;
    set_req(1, 64'h10, 64'h10, ALU_SUB);
    req_valid = 2'b10;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL sub_ready: got %b want 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({resp_valid, resp_data, resp_zero, busy} !== {2'b10, 64'd0, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL sub_hold[%0d]: got rv=%b data=%h z=%b busy=%b want 10 0 1 1",
                 i, resp_valid, resp_data, resp_zero, busy);
      end
      if (i < 3) tick();
    end
    resp_ready = 2'b11;
    tick();
    n_cmp++;
    if ({resp_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL sub_release: got rv=%b busy=%b want 00 0", resp_valid, busy);
    end
  endtask

  task automatic test_fairness();
    logic [0:0]  exp_id;
    logic [1:0]  exp_oh;
    logic [63:0] exp_data;
    resp_ready = 2'b11;
    set_req(0, 64'hF0, 64'h3C, ALU_AND);
    set_req(1, 64'hF0, 64'h0F, ALU_OR);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_id   = 1'(k % 2);
      exp_oh   = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (k % 2 == 0) ? 64'h30 : 64'hFF;
      #1;
      n_cmp++;
      if (req_ready !== exp_oh) begin
        n_fail++; $display("FAIL fair_ready[%0d]: got %b want %b", k, req_ready, exp_oh);
      end
      tick();
      n_cmp++;
      if (grant_id !== exp_id) begin
        n_fail++; $display("FAIL fair_gid[%0d]: got %0d want %0d", k, grant_id, exp_id);
      end
      tick();
      n_cmp++;
      if ({resp_valid, resp_data} !== {exp_oh, exp_data}) begin
        n_fail++;
        $display("FAIL fair_resp[%0d]: got rv=%b data=%h want %b %h",
                 k, resp_valid, resp_data, exp_oh, exp_data);
      end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_wrap_illegal();
    logic [0:0]  gid;
    logic [1:0]  rv;
    logic [63:0] data;
    logic        zero;
    bit          ok;
    do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, gid, rv, data, zero, ok);
    n_cmp++;
    if (!ok || {rv, data, zero} !== {2'b01, 64'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_add: got ok=%0d rv=%b data=%h z=%b want 1 01 0 1", ok, rv, data, zero);
    end
    do_op(0, 64'd5, 64'd3, 3'b011, gid, rv, data, zero, ok);
    n_cmp++;
    if (!ok || {rv, data, zero} !== {2'b01, 64'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_op: got ok=%0d rv=%b data=%h z=%b want 1 01 0 1", ok, rv, data, zero);
    end
    n_cmp++;
    if ({busy, alu_ctrl} !== {1'b0, 3'b011}) begin
      n_fail++; $display("FAIL illegal_idle: got busy=%b ctrl=%b want 0 011", busy, alu_ctrl);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [0:0]  gid;
    logic [1:0]  rv;
    logic [63:0] data;
    logic        zero;
    bit          ok;
    do_op(1, 64'h0A, 64'h05, ALU_OR, gid, rv, data, zero, ok);
    n_cmp++;
    if (!ok || data !== 64'h0F) begin
      n_fail++; $display("FAIL rst_pre: got ok=%0d data=%h want 1 f", ok, data);
    end
    set_req(0, 64'd3, 64'd4, ALU_ADD);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if ({busy, alu_a} !== {1'b1, 64'd3}) begin
      n_fail++; $display("FAIL rst_exec: got busy=%b a=%h want 1 3", busy, alu_a);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({alu_a, alu_b, alu_ctrl, resp_data, resp_zero, resp_valid, req_ready, busy, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got a=%h b=%h ctrl=%b data=%h z=%b rv=%b rdy=%b busy=%b gid=%0d want all 0",
               alu_a, alu_b, alu_ctrl, resp_data, resp_zero, resp_valid, req_ready, busy, grant_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({resp_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_stale: got rv=%b busy=%b want 00 0", resp_valid, busy);
    end
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rst_pointer: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
    do_op(1, 64'h100, 64'h23, ALU_ADD, gid, rv, data, zero, ok);
    n_cmp++;
    if (!ok || {gid, rv, data} !== {1'b1, 2'b10, 64'h123}) begin
      n_fail++;
      $display("FAIL rst_req1: got ok=%0d gid=%0d rv=%b data=%h want 1 1 10 123", ok, gid, rv, data);
    end
  endtask

  task automatic test_hold_while_busy();
    resp_ready = 2'b11;
    set_req(0, 64'hFF, 64'h0F, ALU_AND);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    set_req(1, 64'h20, 64'h22, ALU_ADD);
    req_valid[1] = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL hold_exec_ready: got %b want 00", req_ready);
    end
    tick();
    n_cmp++;
    if ({req_ready, resp_valid, resp_data} !== {2'b00, 2'b01, 64'h0F}) begin
      n_fail++;
      $display("FAIL hold_resp: got rdy=%b rv=%b data=%h want 00 01 f", req_ready, resp_valid, resp_data);
    end
    tick();
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL hold_idle_ready: got %b want 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_cmp++;
    if ({grant_id, alu_a, alu_b, alu_ctrl} !== {1'b1, 64'h20, 64'h22, ALU_ADD}) begin
      n_fail++;
      $display("FAIL hold_operands: got gid=%0d a=%h b=%h ctrl=%b want 1 20 22 010",
               grant_id, alu_a, alu_b, alu_ctrl);
    end
    tick();
    n_cmp++;
    if ({resp_valid, resp_data} !== {2'b10, 64'h42}) begin
      n_fail++; $display("FAIL hold_result: got rv=%b data=%h want 10 42", resp_valid, resp_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_backpressure();
    test_fairness();
    test_wrap_illegal();
    test_reset_mid_op();
    test_hold_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
